// File: rtl/if_buf_writer_if.sv
`default_nettype none
// ============================================================================
// if_buf_writer_if : stream, configuration and FIFO-write signals of if_buf_writer
// Rev 1.0
// ============================================================================
interface if_buf_writer_if #(
  parameter int IF_SCRATCH_WIDTH = 8,
  parameter int LEN_WIDTH        = 8
);
  logic                               start;
  logic        [LEN_WIDTH-1:0]        row_len;
  logic        [LEN_WIDTH-1:0]        num_rows;
  logic                               in_valid;
  logic signed [IF_SCRATCH_WIDTH-1:0] in_data;
  logic                               in_ready;
  logic                               buf_full;
  logic                               buf_write;
  logic        [IF_SCRATCH_WIDTH+1:0] buf_wdata;
  logic                               busy;
  logic                               done;

  modport slave (
    input  start, row_len, num_rows, in_valid, in_data, buf_full,
    output in_ready, buf_write, buf_wdata, busy, done
  );

  modport master (
    output start, row_len, num_rows, in_valid, in_data, buf_full,
    input  in_ready, buf_write, buf_wdata, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/if_buf_writer.sv
`default_nettype none
// ============================================================================
// if_buf_writer : tags IF words with start/end-of-row flags and writes them to
// the IF FIFO through a 2-entry skid stage. Option macro: IF_ZERO_SKIP_EN.
// Rev 1.0
// ============================================================================
module if_buf_writer #(
  parameter int IF_SCRATCH_WIDTH = 8,
  parameter int LEN_WIDTH        = 8
) (
  input  wire logic      clk,
  input  wire logic      rst,
  if_buf_writer_if.slave s_if
);
  localparam int WW = IF_SCRATCH_WIDTH + 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);

  logic [1:0]           r_state;
  logic [LEN_WIDTH-1:0] r_row_len;
  logic [LEN_WIDTH-1:0] r_num_rows;
  logic [LEN_WIDTH-1:0] r_col;
  logic [LEN_WIDTH-1:0] r_row;
  logic [WW-1:0]        r_skid0;
  logic [WW-1:0]        r_skid1;
  logic [1:0]           r_cnt;

  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_skip;
  logic          w_sor;
  logic          w_eor;
  logic          w_last;
  logic [WW-1:0] w_word;
  logic [1:0]    w_cnt_nxt;
  logic [1:0]    w_slot;

  assign s_if.in_ready  = (r_state == S_RUN) && (r_cnt < 2'd2);
  assign s_if.buf_write = w_pop;
  assign s_if.buf_wdata = w_pop ? r_skid0 : '0;
  assign s_if.busy      = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign s_if.done      = (r_state == S_DONE);

  assign w_accept = s_if.in_valid && s_if.in_ready;
  assign w_pop    = (r_cnt != 2'd0) && !s_if.buf_full;
  assign w_sor    = (r_col == '0);
  assign w_eor    = (r_col == r_row_len - c_len_one);
  assign w_last   = w_eor && (r_row == r_num_rows - c_len_one);
  assign w_word   = {w_sor, w_eor, s_if.in_data};

`ifdef IF_ZERO_SKIP_EN
  // Interior zeros are consumed without occupying a FIFO slot.
  assign w_skip = (s_if.in_data == '0) && !w_sor && !w_eor;
`else
  assign w_skip = 1'b0;
`endif

  assign w_push = w_accept && !w_skip;
  assign w_slot = w_pop ? (r_cnt - 2'd1) : r_cnt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_row_len  <= c_len_one;
      r_num_rows <= c_len_one;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (s_if.start) begin
            r_row_len  <= (s_if.row_len  == '0) ? c_len_one : s_if.row_len;
            r_num_rows <= (s_if.num_rows == '0) ? c_len_one : s_if.num_rows;
            r_col      <= '0;
            r_row      <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_eor) begin
              r_col <= '0;
              r_row <= w_last ? '0 : (r_row + c_len_one);
            end else begin
              r_col <= r_col + c_len_one;
            end
            if (w_last) begin
              r_state <= S_FLUSH;
            end
          end
        end
        // Leave FLUSH on the cycle the final entry drains so done follows it directly.
        S_FLUSH: begin
          if (w_cnt_nxt == 2'd0) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid0 <= '0;
      r_skid1 <= '0;
      r_cnt   <= 2'd0;
    end else begin
      if (w_pop) begin
        r_skid0 <= r_skid1;
      end
      if (w_push) begin
        if (w_slot == 2'd0) begin
          r_skid0 <= w_word;
        end else begin
          r_skid1 <= w_word;
        end
      end
      r_cnt <= w_cnt_nxt;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_if_buf_writer.sv
`default_nettype none
// ============================================================================
// tb_if_buf_writer : randomized self-checking bench for if_buf_writer against
// a queue-based frame model. Rev 1.0
// ============================================================================
module tb_if_buf_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  if_buf_writer_if #(.IF_SCRATCH_WIDTH(8), .LEN_WIDTH(8)) bus();

  if_buf_writer #(.IF_SCRATCH_WIDTH(8), .LEN_WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words expected at the FIFO, in order, not yet written.
  logic [9:0] m_q[$];
  bit         m_active;
  bit         m_draining;
  bit         m_done;
  int         m_R;
  int         m_N;
  int         m_k;
  bit         t_acc;
  logic signed [7:0] words [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active   = 1'b0;
    m_draining = 1'b0;
    m_done     = 1'b0;
    m_k        = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_buf_write"}, 32'(bus.buf_write), 32'd0);
    chk({tag, "_buf_wdata"}, 32'(bus.buf_wdata), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_done"},      32'(bus.done),      32'd0);
  endtask

  // One clock: compare outputs at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit         exp_rdy, exp_wr, st, sor, eor, skip;
    logic [9:0] exp_wd;
    logic [7:0] d, rl, nr;
    int         col;
    @(negedge clk);
    exp_rdy = m_active && (m_q.size() < 2);
    exp_wr  = (m_q.size() > 0) && !bus.buf_full;
    exp_wd  = exp_wr ? m_q[0] : 10'd0;
    chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    chk("buf_write", 32'(bus.buf_write), 32'(exp_wr));
    chk("buf_wdata", 32'(bus.buf_wdata), 32'(exp_wd));
    chk("busy",      32'(bus.busy),      32'(m_active || m_draining));
    chk("done",      32'(bus.done),      32'(m_done));
    t_acc = bus.in_valid && exp_rdy;
    st    = bus.start && !m_active && !m_draining && !m_done;
    d     = bus.in_data;
    rl    = bus.row_len;
    nr    = bus.num_rows;
    @(posedge clk);
    m_done = 1'b0;
    if (exp_wr) void'(m_q.pop_front());
    if (st) begin
      m_R      = (rl == 0) ? 1 : int'(rl);
      m_N      = (nr == 0) ? 1 : int'(nr);
      m_k      = 0;
      m_active = 1'b1;
    end
    if (t_acc) begin
      col = m_k % m_R;
      sor = (col == 0);
      eor = (col == m_R - 1);
`ifdef IF_ZERO_SKIP_EN
      skip = (d == 8'd0) && !sor && !eor;
`else
      skip = 1'b0;
`endif
      if (!skip) m_q.push_back({sor, eor, d});
      m_k++;
      if (m_k == m_R * m_N) begin
        m_active   = 1'b0;
        m_draining = 1'b1;
      end
    end
    if (m_draining && m_q.size() == 0) begin
      m_draining = 1'b0;
      m_done     = 1'b1;
    end
    #1;
  endtask

  task automatic run_frame(input int R, input int N, input int vpct, input int fpct,
                           input int spct, input int flo, input int fhi);
    int idx;
    int total;
    int cyc;
    bit seen_done;
    idx       = 0;
    cyc       = 0;
    seen_done = 1'b0;
    total     = ((R == 0) ? 1 : R) * ((N == 0) ? 1 : N);
    bus.row_len  = 8'(R);
    bus.num_rows = 8'(N);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    bus.buf_full = 1'b0;
    tick();
    bus.start = 1'b0;
    while (!seen_done && cyc < 2000) begin
      bus.in_valid = ($urandom_range(99) < vpct);
      bus.in_data  = words[(idx < 64) ? idx : 0];
      bus.buf_full = (cyc >= flo && cyc <= fhi) || ($urandom_range(99) < fpct);
      bus.start    = ($urandom_range(99) < spct);
      if (bus.start) begin
        bus.row_len  = 8'($urandom);
        bus.num_rows = 8'($urandom);
      end
      seen_done = m_done;
      tick();
      if (t_acc) idx++;
      cyc++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.buf_full = 1'b0;
    if (!seen_done) chk("frame_timeout", 32'd0, 32'd1);
    chk("frame_words_accepted", 32'(idx), 32'(total));
  endtask

  initial begin
    int acc;
    int guard;
    model_reset();
    bus.start    = 1'b0;
    bus.row_len  = 8'd0;
    bus.num_rows = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'sd0;
    bus.buf_full = 1'b0;
    #1;
    check_all_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 4x2 frame, data 1..8 back-to-back
    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
    run_frame(4, 2, 100, 0, 0, -1, -2);

    // single-word rows
    words[0] = 8'sd5; words[1] = 8'sd6; words[2] = 8'sd7;
    run_frame(1, 3, 100, 0, 0, -1, -2);

    // FIFO full window mid-frame
    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
    run_frame(4, 2, 100, 0, 0, 3, 6);

    // zeros inside a row
    words[0] = -8'sd3; words[1] = 8'sd0; words[2] = 8'sd0; words[3] = 8'sd4;
    run_frame(4, 1, 100, 0, 0, -1, -2);

    // stray start pulses during the frame
    for (int i = 0; i < 8; i++) words[i] = 8'(i + 1);
    run_frame(4, 2, 100, 0, 40, -1, -2);

    // asynchronous reset after three accepted words
    bus.row_len  = 8'd4;
    bus.num_rows = 8'd2;
    bus.start    = 1'b1;
    tick();
    bus.start = 1'b0;
    acc   = 0;
    guard = 0;
    while (acc < 3 && guard < 20) begin
      bus.in_valid = 1'b1;
      bus.in_data  = words[acc];
      tick();
      if (t_acc) acc++;
      guard++;
    end
    chk("pre_reset_accepts", 32'(acc), 32'd3);
    #2 rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    model_reset();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(4, 2, 100, 0, 0, -1, -2);

    // randomized frames: geometry, data, valid gaps, FIFO backpressure, stray starts
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 64; i++)
        words[i] = ($urandom_range(2) == 0) ? 8'sd0 : 8'($urandom);
      run_frame(int'($urandom_range(5)), int'($urandom_range(3)), 70, 30, 10, -1, -2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
